// File: rtl/riscv_hwloop_controller.sv
// rtl/riscv_hwloop_controller.sv - hardware-loop end detection, counter decrement and fetch redirect request
module riscv_hwloop_controller #(
   parameter int N_REGS     = 2,
   parameter int N_REG_BITS = $clog2(N_REGS)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [31:0]            current_pc_i,
   input  logic                   instr_valid_i,
   input  logic                   id_valid_i,
   input  logic                   flush_i,
   input  logic [N_REGS*32-1:0]   hwlp_start_addr_i,
   input  logic [N_REGS*32-1:0]   hwlp_end_addr_i,
   input  logic [N_REGS*32-1:0]   hwlp_counter_i,
   output logic [N_REGS-1:0]      hwlp_dec_cnt_o,
   output logic                   jump_req_o,
   output logic [31:0]            jump_target_o,
   input  logic                   jump_ack_i,
   output logic                   hwlp_busy_o
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT_RET} state_e;

   state_e                state_q, state_d;
   logic [31:0]           target_q, target_d;
   logic                  ret_q, ret_d;

   logic [N_REGS-1:0]     match;
   logic                  any_match;
   logic [N_REG_BITS-1:0] sel;
   logic [31:0]           sel_cnt;
   logic [31:0]           sel_start;
   logic                  jump_needed;

   // Index 0 is the innermost loop, so the lowest matching index wins.
   always_comb begin
      match     = '0;
      sel       = '0;
      for (int k = 0; k < N_REGS; k++) begin
         match[k] = instr_valid_i
                    && (current_pc_i == hwlp_end_addr_i[k*32 +: 32])
                    && (hwlp_counter_i[k*32 +: 32] != 32'd0);
      end
      for (int k = N_REGS - 1; k >= 0; k--) begin
         if (match[k]) begin
            sel = N_REG_BITS'(k);
         end
      end
      any_match   = |match;
      sel_cnt     = hwlp_counter_i[32'(sel)*32 +: 32];
      sel_start   = hwlp_start_addr_i[32'(sel)*32 +: 32];
      jump_needed = any_match && (sel_cnt > 32'd1);
      hwlp_dec_cnt_o = '0;
      if (any_match && !flush_i && rst_n) begin
         hwlp_dec_cnt_o[sel] = 1'b1;
      end
   end

   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      ret_d    = ret_q;
      if (flush_i) begin
         state_d = IDLE;
         ret_d   = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (jump_needed) begin
                  state_d  = REQ;
                  target_d = sel_start;
                  ret_d    = id_valid_i;
               end
            end
            REQ: begin
               ret_d = ret_q | id_valid_i;
               if (jump_ack_i) begin
                  // The end instruction must have left ID before another match is honoured.
                  if (ret_q || id_valid_i) begin
                     state_d = IDLE;
                     ret_d   = 1'b0;
                  end else begin
                     state_d = WAIT_RET;
                  end
               end
            end
            WAIT_RET: begin
               if (id_valid_i) begin
                  state_d = IDLE;
                  ret_d   = 1'b0;
               end
            end
            default: begin
               state_d = IDLE;
               ret_d   = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         target_q <= 32'd0;
         ret_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
         ret_q    <= ret_d;
      end
   end

   assign jump_req_o    = (state_q == REQ);
   assign jump_target_o = target_q;
   assign hwlp_busy_o   = (state_q != IDLE);

endmodule
